fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 211 +++++++++++++++++++++
 tb/tb_fetch_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// fetch_seq: byte-serial instruction fetch, issue handshake and single-cycle load/store.
// Optional boot-shadow region forcing is enabled by defining FETCH_SEQ_BOOT_SHADOW_EN.
module fetch_seq #(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       INSTR_BYTES = 2,
    parameter int unsigned       SEL_W       = 3,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_oe_n,
    output logic                          mem_we_n,
    output logic [(1<<SEL_W)-1:0]         mem_sel_n,
    input  logic [SEL_W-1:0]              ctrl_sel,
    input  logic                          boot_clear,
    output logic [INSTR_BYTES*DATA_W-1:0] instr,
    output logic                          instr_valid,
    input  logic                          exec_ack,
    input  logic                          jmp_abs_en,
    input  logic [ADDR_W-1:0]             jmp_abs_addr,
    input  logic                          jmp_rel_en,
    input  logic [DATA_W-1:0]             jmp_rel_off,
    input  logic                          ls_req,
    input  logic                          ls_we,
    input  logic [ADDR_W-1:0]             ls_addr,
    input  logic [DATA_W-1:0]             ls_wdata,
    output logic [DATA_W-1:0]             ls_rdata,
    output logic                          ls_done
);

    localparam int unsigned IW = INSTR_BYTES * DATA_W;
    localparam int unsigned KW = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {
        S_FETCH,
        S_ISSUE,
        S_MEM
    } state_e;

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [IW-1:0]       instr_q, instr_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                ls_done_q, ls_done_d;
    logic                ls_we_q, ls_we_d;
    logic [ADDR_W-1:0]   ls_addr_q, ls_addr_d;
    logic [DATA_W-1:0]   ls_wdata_q, ls_wdata_d;
    logic [SEL_W-1:0]    fetch_sel;
    logic [ADDR_W-1:0]   pc_seq;
    logic [ADDR_W-1:0]   rel_ext;
    logic [ADDR_W-1:0]   pc_jmp;

`ifdef FETCH_SEQ_BOOT_SHADOW_EN
    logic boot_q, boot_d;

    always_comb begin
        boot_d = boot_q;
        if (boot_clear) begin
            boot_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            boot_q <= 1'b1;
        end else begin
            boot_q <= boot_d;
        end
    end

    assign fetch_sel = boot_q ? '0 : ctrl_sel;
`else
    logic unused_boot_clear;

    assign unused_boot_clear = boot_clear;
    assign fetch_sel         = ctrl_sel;
`endif

    // All PC arithmetic wraps naturally at ADDR_W bits.
    assign pc_seq  = pc_q + ADDR_W'(INSTR_BYTES);
    assign rel_ext = ADDR_W'(signed'(jmp_rel_off));

    always_comb begin
        pc_jmp = pc_seq;
        if (jmp_abs_en) begin
            pc_jmp = jmp_abs_addr;
        end else if (jmp_rel_en) begin
            pc_jmp = pc_q + rel_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            k_q        <= '0;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            ls_rdata_q <= '0;
            ls_done_q  <= 1'b0;
            ls_we_q    <= 1'b0;
            ls_addr_q  <= '0;
            ls_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            ls_rdata_q <= ls_rdata_d;
            ls_done_q  <= ls_done_d;
            ls_we_q    <= ls_we_d;
            ls_addr_q  <= ls_addr_d;
            ls_wdata_q <= ls_wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        ls_rdata_d = ls_rdata_q;
        ls_done_d  = 1'b0;
        ls_we_d    = ls_we_q;
        ls_addr_d  = ls_addr_q;
        ls_wdata_d = ls_wdata_q;
        case (state_q)
            S_FETCH: begin
                for (int i = 0; i < int'(INSTR_BYTES); i++) begin
                    if (k_q == KW'(i)) begin
                        instr_d[i*DATA_W +: DATA_W] = mem_rdata;
                    end
                end
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = S_ISSUE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_ISSUE: begin
                // Jump and load/store inputs matter only in the ack cycle.
                if (exec_ack) begin
                    if (ls_req) begin
                        ls_we_d    = ls_we;
                        ls_addr_d  = ls_addr;
                        ls_wdata_d = ls_wdata;
                        state_d    = S_MEM;
                    end else begin
                        pc_d    = pc_jmp;
                        state_d = S_FETCH;
                    end
                end
            end
            S_MEM: begin
                if (!ls_we_q) begin
                    ls_rdata_d = mem_rdata;
                end
                ls_done_d = 1'b1;
                pc_d      = pc_seq;
                state_d   = S_FETCH;
            end
            default: begin
                k_d     = '0;
                state_d = S_FETCH;
            end
        endcase
    end

    always_comb begin
        mem_addr  = pc_q;
        mem_wdata = '0;
        mem_oe_n  = 1'b1;
        mem_we_n  = 1'b1;
        mem_sel_n = '1;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_addr             = pc_q + ADDR_W'(k_q);
                    mem_oe_n             = 1'b0;
                    mem_sel_n[fetch_sel] = 1'b0;
                end
                S_MEM: begin
                    mem_addr            = ls_addr_q;
                    mem_sel_n[ctrl_sel] = 1'b0;
                    if (ls_we_q) begin
                        mem_we_n  = 1'b0;
                        mem_wdata = ls_wdata_q;
                    end else begin
                        mem_oe_n = 1'b0;
                    end
                end
                default: begin
                    mem_addr = pc_q;
                end
            endcase
        end
    end

    // Reset forces every visible output idle even before the first edge.
    assign instr       = rst ? '0 : instr_q;
    assign instr_valid = !rst && (state_q == S_ISSUE);
    assign ls_rdata    = rst ? '0 : ls_rdata_q;
    assign ls_done     = !rst && ls_done_q;

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: vectors, corner sequences and random ops checked against a rule-level model.
// Boot-shadow expectations follow FETCH_SEQ_BOOT_SHADOW_EN when defined.
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_wdata;
    logic        mem_oe_n;
    logic        mem_we_n;
    logic [7:0]  mem_sel_n;
    logic [2:0]  ctrl_sel;
    logic        boot_clear;
    logic [15:0] instr;
    logic        instr_valid;
    logic        exec_ack;
    logic        jmp_abs_en;
    logic [15:0] jmp_abs_addr;
    logic        jmp_rel_en;
    logic [7:0]  jmp_rel_off;
    logic        ls_req;
    logic        ls_we;
    logic [15:0] ls_addr;
    logic [7:0]  ls_wdata;
    logic [7:0]  ls_rdata;
    logic        ls_done;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:65535];
    bit         boot_m;
    logic [7:0] ls_rd_m;

    typedef struct {
        bit          ae;
        logic [15:0] aa;
        bit          re;
        logic [7:0]  ro;
        bit          lr;
        bit          lw;
        logic [15:0] la;
        logic [7:0]  ld;
        int          stall;
        bit          clr;
    } op_t;

    typedef struct {
        logic [15:0] pc0;
        bit          ae;
        logic [15:0] aa;
        bit          re;
        logic [7:0]  ro;
        logic [15:0] exp;
    } vec_t;

    fetch_seq dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_wdata    (mem_wdata),
        .mem_oe_n     (mem_oe_n),
        .mem_we_n     (mem_we_n),
        .mem_sel_n    (mem_sel_n),
        .ctrl_sel     (ctrl_sel),
        .boot_clear   (boot_clear),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .exec_ack     (exec_ack),
        .jmp_abs_en   (jmp_abs_en),
        .jmp_abs_addr (jmp_abs_addr),
        .jmp_rel_en   (jmp_rel_en),
        .jmp_rel_off  (jmp_rel_off),
        .ls_req       (ls_req),
        .ls_we        (ls_we),
        .ls_addr      (ls_addr),
        .ls_wdata     (ls_wdata),
        .ls_rdata     (ls_rdata),
        .ls_done      (ls_done)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("strobe_excl", {31'd0, !mem_oe_n && !mem_we_n}, 32'd0);
    end

    function automatic logic [7:0] seln(input int s);
        return ~(8'd1 << s);
    endfunction

    function automatic logic [15:0] model_npc(input logic [15:0] pc,
                                              input op_t op);
        int t;
        if (op.lr) return pc + 16'd2;
        if (op.ae) return op.aa;
        if (op.re) begin
            t = int'(pc) + int'($signed(op.ro));
            return 16'(t & 'hFFFF);
        end
        return pc + 16'd2;
    endfunction

    task automatic garbage();
        jmp_abs_en   = 1'($urandom);
        jmp_abs_addr = 16'($urandom);
        jmp_rel_en   = 1'($urandom);
        jmp_rel_off  = 8'($urandom);
        ls_req       = 1'($urandom);
        ls_we        = 1'($urandom);
        ls_addr      = 16'($urandom);
        ls_wdata     = 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exec_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, instr_valid}, 0);
        chk("rst_instr", {16'd0, instr}, 0);
        chk("rst_oe", {31'd0, mem_oe_n}, 1);
        chk("rst_we", {31'd0, mem_we_n}, 1);
        chk("rst_sel", {24'd0, mem_sel_n}, 32'hFF);
        chk("rst_lsrd", {24'd0, ls_rdata}, 0);
        chk("rst_done", {31'd0, ls_done}, 0);
        rst = 1'b0;
        ls_rd_m = 8'h00;
`ifdef FETCH_SEQ_BOOT_SHADOW_EN
        boot_m = 1'b1;
`else
        boot_m = 1'b0;
`endif
    endtask

    // Entered at the negedge of the FETCH k=0 cycle; leaves at the next one.
    task automatic do_instr(input logic [15:0] pc, input op_t op,
                            output logic [15:0] npc);
        logic [15:0] a1;
        logic [15:0] ei;
        a1 = pc + 16'd1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("fetch_addr", {16'd0, mem_addr}, {16'd0, pc + 16'(k)});
            chk("fetch_oe", {31'd0, mem_oe_n}, 0);
            chk("fetch_we", {31'd0, mem_we_n}, 1);
            chk("fetch_sel", {24'd0, mem_sel_n},
                {24'd0, seln(boot_m ? 0 : int'(ctrl_sel))});
            chk("fetch_valid", {31'd0, instr_valid}, 0);
            if (k > 0) chk("done_width", {31'd0, ls_done}, 0);
            @(negedge clk);
        end
        ei = {mem[a1], mem[pc]};
        chk("issue_valid", {31'd0, instr_valid}, 1);
        chk("issue_instr", {16'd0, instr}, {16'd0, ei});
        chk("issue_sel", {24'd0, mem_sel_n}, 32'hFF);
        chk("issue_oe", {31'd0, mem_oe_n}, 1);
        chk("issue_lsrd", {24'd0, ls_rdata}, {24'd0, ls_rd_m});
        for (int s = 0; s < op.stall; s++) begin
            if (op.clr && s == 0) boot_clear = 1'b1;
            @(negedge clk);
            boot_clear = 1'b0;
`ifdef FETCH_SEQ_BOOT_SHADOW_EN
            if (op.clr && s == 0) boot_m = 1'b0;
`endif
            chk("stall_valid", {31'd0, instr_valid}, 1);
            chk("stall_instr", {16'd0, instr}, {16'd0, ei});
        end
        exec_ack     = 1'b1;
        jmp_abs_en   = op.ae;
        jmp_abs_addr = op.aa;
        jmp_rel_en   = op.re;
        jmp_rel_off  = op.ro;
        ls_req       = op.lr;
        ls_we        = op.lw;
        ls_addr      = op.la;
        ls_wdata     = op.ld;
        @(negedge clk);
        exec_ack = 1'b0;
        garbage();
        #1;
        chk("post_valid", {31'd0, instr_valid}, 0);
        if (op.lr) begin
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, op.la});
            chk("mem_sel", {24'd0, mem_sel_n}, {24'd0, seln(int'(ctrl_sel))});
            chk("mem_we", {31'd0, mem_we_n}, {31'd0, !op.lw});
            chk("mem_oe", {31'd0, mem_oe_n}, {31'd0, op.lw});
            if (op.lw) begin
                chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, op.ld});
                if (!mem_we_n) mem[mem_addr] = mem_wdata;
            end else begin
                ls_rd_m = mem[op.la];
            end
            @(negedge clk);
            chk("ls_done", {31'd0, ls_done}, 1);
            chk("ls_rdata", {24'd0, ls_rdata}, {24'd0, ls_rd_m});
        end else begin
            chk("no_done", {31'd0, ls_done}, 0);
        end
        npc = model_npc(pc, op);
    endtask

    initial begin
        vec_t        tbl [8];
        op_t         op;
        op_t         nop;
        logic [15:0] pc;
        logic [15:0] dummy;

        tbl[0] = '{16'h0010, 0, 16'h0000, 1, 8'hF0, 16'h0000};
        tbl[1] = '{16'hFFFE, 0, 16'h0000, 0, 8'h00, 16'h0000};
        tbl[2] = '{16'h0010, 1, 16'h4000, 1, 8'h05, 16'h4000};
        tbl[3] = '{16'h1000, 0, 16'h0000, 1, 8'h05, 16'h1005};
        tbl[4] = '{16'h1000, 0, 16'h0000, 1, 8'h7F, 16'h107F};
        tbl[5] = '{16'h0000, 0, 16'h0000, 1, 8'h80, 16'hFF80};
        tbl[6] = '{16'h1234, 0, 16'h0000, 0, 8'h00, 16'h1236};
        tbl[7] = '{16'h2000, 1, 16'hFFFF, 0, 8'h00, 16'hFFFF};

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0000] = 8'h34;
        mem[16'h0001] = 8'h12;
        mem[16'h8001] = 8'hA5;
        nop = '{0, 16'h0, 0, 8'h0, 0, 0, 16'h0, 8'h0, 0, 0};
        boot_clear = 1'b0;
        ctrl_sel = 3'd1;
        exec_ack = 1'b0;
        garbage();

        do_reset();
        #1;
        chk("first_addr", {16'd0, mem_addr}, 32'h0000);
        @(negedge clk);
        @(negedge clk);
        chk("first_instr", {16'd0, instr}, 32'h1234);
        chk("first_valid", {31'd0, instr_valid}, 1);
        do_reset();

        do_instr(16'h0000, nop, pc);
        op = nop;
        op.lr = 1; op.lw = 0; op.la = 16'h8001; op.stall = 1;
        do_instr(pc, op, pc);
        chk("load_a5", {24'd0, ls_rdata}, 32'hA5);
        op.lw = 1; op.ld = 8'h5A; op.stall = 0;
        do_instr(pc, op, pc);
        chk("store_5a", {24'd0, mem[16'h8001]}, 32'h5A);

        for (int i = 0; i < 8; i++) begin
            op = nop;
            op.ae = 1; op.aa = tbl[i].pc0;
            do_instr(pc, op, pc);
            op = nop;
            op.ae = tbl[i].ae; op.aa = tbl[i].aa;
            op.re = tbl[i].re; op.ro = tbl[i].ro;
            op.stall = i % 3;
            do_instr(tbl[i].pc0, op, dummy);
            pc = tbl[i].exp;
        end

        #1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", {31'd0, instr_valid}, 0);
        chk("abort_instr", {16'd0, instr}, 0);
        chk("abort_oe", {31'd0, mem_oe_n}, 1);
        @(negedge clk);
        chk("abort_valid2", {31'd0, instr_valid}, 0);
        rst = 1'b0;
`ifdef FETCH_SEQ_BOOT_SHADOW_EN
        boot_m = 1'b1;
`endif
        ls_rd_m = 8'h00;
        ctrl_sel = 3'd2;
        do_instr(16'h0000, nop, pc);
        op = nop;
        op.stall = 2; op.clr = 1;
        do_instr(pc, op, pc);
        do_instr(pc, nop, pc);
        chk("boot_cleared", {31'd0, boot_m}, 0);

        for (int n = 0; n < 400; n++) begin
            ctrl_sel = 3'($urandom);
            op.ae    = ($urandom_range(0, 9) == 0);
            op.aa    = 16'($urandom);
            op.re    = ($urandom_range(0, 4) == 0);
            op.ro    = 8'($urandom);
            op.lr    = ($urandom_range(0, 3) == 0);
            op.lw    = 1'($urandom);
            op.la    = 16'($urandom);
            op.ld    = 8'($urandom);
            op.stall = $urandom_range(0, 3);
            op.clr   = 0;
            do_instr(pc, op, pc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
